// File: rtl/date_pkg.sv
// Calendar constants and types shared by the day-of-year <-> date converters.
package date_pkg;

    typedef enum logic [3:0] {
        JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
        MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
        SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
    } month_t;

    localparam int unsigned DAYS_NONLEAP = 365;
    localparam int unsigned DAYS_LEAP    = 366;

    localparam logic [4:0] DAYS_IN_MONTH [1:12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WALK,
        ST_DONE
    } d2d_state_t;

    // Month length for a 1-based month number; 0 for out-of-range codes.
    function automatic logic [4:0] month_days(input logic [3:0] m, input logic leap);
        logic [4:0] d;
        d = '0;
        for (int unsigned i = 1; i <= 12; i++) begin
            if (m == i[3:0]) d = DAYS_IN_MONTH[i];
        end
        if (leap && (m == FEB)) d = 5'd29;
        return d;
    endfunction

endpackage

// File: rtl/leap_year_check.sv
// Simplified leap-year test: every year divisible by four is a leap year.
module leap_year_check #(
    parameter int unsigned YEAR_W = 11
) (
    input  logic [YEAR_W-1:0] year_i,
    output logic              leap_o
);

    // Modulo by a power of two reduces to year_i[1:0] == 0 in hardware.
    assign leap_o = ((year_i % YEAR_W'(4)) == '0);

endmodule

// File: rtl/day_of_year_to_date.sv
// Converts (dayOfYear, year) to (month, dayOfMonth) by walking one month per cycle.
module day_of_year_to_date
    import date_pkg::*;
#(
    parameter int unsigned YEAR_W = 11,
    parameter int unsigned DOY_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DOY_W-1:0]  dayOfYear,
    input  logic [YEAR_W-1:0] year,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        month,
    output logic [5:0]        dayOfMonth,
    output logic              error
);

    d2d_state_t        state_q, state_d;
    logic [DOY_W-1:0]  rem_q, rem_d;
    logic [3:0]        cur_month_q, cur_month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [5:0]        dom_q, dom_d;
    logic              err_q, err_d;

    logic              leap;
    logic [DOY_W-1:0]  limit;
    logic [4:0]        dim;

    leap_year_check #(.YEAR_W(YEAR_W)) u_leap (
        .year_i (year_q),
        .leap_o (leap)
    );

    assign limit = leap ? DOY_W'(DAYS_LEAP) : DOY_W'(DAYS_NONLEAP);
    assign dim   = month_days(cur_month_q, leap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            cur_month_q <= '0;
            year_q      <= '0;
            month_q     <= '0;
            dom_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cur_month_q <= cur_month_d;
            year_q      <= year_d;
            month_q     <= month_d;
            dom_q       <= dom_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cur_month_d = cur_month_q;
        year_d      = year_q;
        month_d     = month_q;
        dom_d       = dom_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // rem doubles as the captured dayOfYear until CHECK validates it.
                    rem_d   = dayOfYear;
                    year_d  = year;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((rem_q == '0) || (rem_q > limit)) begin
                    err_d   = 1'b1;
                    month_d = '0;
                    dom_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cur_month_d = 4'd1;
                    state_d     = ST_WALK;
                end
            end
            ST_WALK: begin
                if (rem_q <= DOY_W'(dim)) begin
                    month_d = cur_month_q;
                    dom_d   = rem_q[5:0];
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    rem_d       = rem_q - DOY_W'(dim);
                    cur_month_d = cur_month_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    month_d = '0;
                    dom_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign month      = month_q;
    assign dayOfMonth = dom_q;
    assign error      = err_q;

endmodule

// File: tb/tb_day_of_year_to_date.sv
// Directed table-driven bench for day_of_year_to_date plus backpressure and reset corners.
module tb_day_of_year_to_date;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  dayOfYear;
    logic [10:0] year;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  month;
    logic [5:0]  dayOfMonth;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    day_of_year_to_date #(.YEAR_W(11), .DOY_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dayOfYear  (dayOfYear),
        .year       (year),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .month      (month),
        .dayOfMonth (dayOfMonth),
        .error      (error)
    );

    typedef struct {
        int doy;
        int yr;
        int m;
        int d;
        int err;
        int lat;
    } vec_t;

    // The last month must never need more than 31 days.
    always @(negedge clk) begin
        if (!rst && dut.state_q == date_pkg::ST_WALK && dut.cur_month_q == 4'd12) begin
            assert (dut.rem_q <= 9'd31)
            else begin
                errors++;
                $display("FAIL walk_dec_bound: rem=%0d required <=31", dut.rem_q);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one request and checks result fields and latency (edges from accept to first sampled out_valid).
    task automatic run_vec(input string tag, input int doy, input int yr,
                           input int em, input int ed, input int eerr, input int elat);
        int  lat;
        bit  seen;
        @(negedge clk);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        dayOfYear = 9'(doy);
        year      = 11'(yr);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dayOfYear = 9'(doy + 77);
        year      = 11'(yr + 1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=0 expected 1 within 20 cycles", tag);
            return;
        end
        chk({tag, "_latency"}, lat + 1, elat);
        chk({tag, "_month"}, int'(month), em);
        chk({tag, "_day"}, int'(dayOfMonth), ed);
        chk({tag, "_error"}, int'(error), eerr);
        @(posedge clk);
        #1;
        chk({tag, "_post_ready"}, int'(in_ready), 1);
        chk({tag, "_post_valid"}, int'(out_valid), 0);
        chk({tag, "_post_month"}, int'(month), 0);
    endtask

    initial begin
        vec_t vecs[$];
        bit   leaked;

        vecs.push_back('{1,   2023, 1,  1,  0, 3});
        vecs.push_back('{60,  2024, 2,  29, 0, 4});
        vecs.push_back('{60,  2023, 3,  1,  0, 5});
        vecs.push_back('{366, 2024, 12, 31, 0, 14});
        vecs.push_back('{366, 2023, 0,  0,  1, 2});
        vecs.push_back('{0,   2000, 0,  0,  1, 2});
        vecs.push_back('{365, 2000, 12, 30, 0, 14});
        vecs.push_back('{31,  2023, 1,  31, 0, 3});
        vecs.push_back('{32,  2023, 2,  1,  0, 4});
        vecs.push_back('{59,  2023, 2,  28, 0, 4});
        vecs.push_back('{61,  2024, 3,  1,  0, 5});
        vecs.push_back('{365, 2023, 12, 31, 0, 14});
        vecs.push_back('{367, 2024, 0,  0,  1, 2});
        vecs.push_back('{511, 2024, 0,  0,  1, 2});
        vecs.push_back('{300, 2023, 10, 27, 0, 12});
        vecs.push_back('{335, 2024, 11, 30, 0, 13});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dayOfYear = '0;
        year      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_month", int'(month), 0);
        chk("reset_day", int'(dayOfMonth), 0);

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].doy, vecs[i].yr,
                    vecs[i].m, vecs[i].d, vecs[i].err, vecs[i].lat);

        // Backpressure: result must hold while the consumer stalls.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dayOfYear = 9'd200;
        year      = 11'd2023;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_month", int'(month), 7);
            chk("bp_day", int'(dayOfMonth), 19);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        chk("bp_still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(out_valid), 0);

        // Reset pulse mid-walk abandons the request.
        @(negedge clk);
        in_valid  = 1'b1;
        dayOfYear = 9'd300;
        year      = 11'd2023;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        chk("rst_mid_month", int'(month), 0);
        chk("rst_mid_day", int'(dayOfMonth), 0);
        chk("rst_mid_error", int'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) leaked = 1'b1;
        end
        chk("rst_no_output", int'(leaked), 0);
        run_vec("after_rst", 300, 2024, 10, 26, 0, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
